// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - shared state encoding and sizing constants for fifo_drain
package fifo_drain_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POP  = 2'd1,
      CAPT = 2'd2
   } state_t;

   localparam int SKID_DEPTH = 2;
   localparam int STAT_W     = 32;

endpackage

// File: rtl/drain_skid.sv
// rtl/drain_skid.sv - 2-entry in-order skid buffer holding words popped from the FIFO
module drain_skid
   import fifo_drain_pkg::*;
#(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [width-1:0] push_data,
   input  logic             pop,
   output logic [width-1:0] head,
   output logic [1:0]       occ
);

   localparam logic [1:0] FULL = 2'(SKID_DEPTH);

   logic [width-1:0] entry0;
   logic [width-1:0] entry1;
   logic             pop_ok;
   logic             push_ok;

   // A pop frees a slot in the same cycle, so push is allowed into a full buffer when draining.
   assign pop_ok  = pop && (occ != 2'd0);
   assign push_ok = push && ((occ != FULL) || pop_ok);
   assign head    = entry0;

   always_ff @(posedge clk) begin
      if (reset) begin
         entry0 <= '0;
         entry1 <= '0;
         occ    <= 2'd0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10: begin
               if (occ == 2'd0) entry0 <= push_data;
               else             entry1 <= push_data;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               entry0 <= entry1;
               occ    <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  entry0 <= push_data;
               end else begin
                  entry0 <= entry1;
                  entry1 <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fifo_drain.sv
// rtl/fifo_drain.sv - FIFO read-side controller with valid/ready output; FIFO_DRAIN_STATS_EN adds counters
module fifo_drain
   import fifo_drain_pkg::*;
#(
   parameter int width = 8
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              empty_i,
   input  logic [width-1:0]  fifo_dout_i,
   output logic              rd_en_o,
   output logic [width-1:0]  data_o,
   output logic              valid_o,
   input  logic              ready_i
`ifdef FIFO_DRAIN_STATS_EN
   ,
   output logic [STAT_W-1:0] pop_cnt_o,
   output logic [STAT_W-1:0] stall_cnt_o
`endif
);

   localparam logic [1:0] FULL = 2'(SKID_DEPTH);

   state_t     state;
   state_t     state_next;
   logic [1:0] occ;
   logic       capture;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state   <= IDLE;
         rd_en_o <= 1'b0;
      end else begin
         state   <= state_next;
         rd_en_o <= (state_next == POP);
      end
   end

   // empty_i is only trusted in IDLE; in CAPT it still reflects the FIFO before the last pop.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (!empty_i && (occ < FULL)) state_next = POP;
         POP:     state_next = CAPT;
         CAPT:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      capture = (state == CAPT);
      valid_o = (occ != 2'd0);
   end

   drain_skid #(.width(width)) skid (
      .clk       (clk_i),
      .reset     (reset_i),
      .push      (capture),
      .push_data (fifo_dout_i),
      .pop       (valid_o && ready_i),
      .head      (data_o),
      .occ       (occ)
   );

`ifdef FIFO_DRAIN_STATS_EN
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pop_cnt_o   <= '0;
         stall_cnt_o <= '0;
      end else begin
         if (rd_en_o)               pop_cnt_o   <= pop_cnt_o + 1'b1;
         if (valid_o && !ready_i)   stall_cnt_o <= stall_cnt_o + 1'b1;
      end
   end
`endif

endmodule

// File: doc/fifo_drain.md
# fifo_drain

Read-side controller for the team's synchronous FIFO. It pops words from the FIFO's read port, absorbs the FIFO's one-cycle read latency and its lagging `empty` flag, and presents the words to a downstream consumer (e.g. the Lease Cache memory-controller request path) over a valid/ready handshake. It sits between the FIFO's `rd_en`/`dout`/`empty` signals and any consumer that may stall.

## Interface
Parameters:
- `width`, 8, data word width; must equal the attached FIFO's `width`.

Ports:
- `clk_i`  in  1  single clock; all logic is on the rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `empty_i`  in  1  FIFO empty flag. It lags one cycle after a pop empties the FIFO.
- `fifo_dout_i`  in  width  FIFO read data. It is valid in the cycle after `rd_en_o` is sampled high.
- `rd_en_o`  out  1  pop request to the FIFO; registered.
- `data_o`  out  width  head word presented downstream.
- `valid_o`  out  1  `data_o` holds a word.
- `ready_i`  in  1  downstream accepts when `valid_o && ready_i`.
- `pop_cnt_o`  out  32  words popped; present only with `FIFO_DRAIN_STATS_EN`.
- `stall_cnt_o`  out  32  cycles with `valid_o && !ready_i`; present only with `FIFO_DRAIN_STATS_EN`.

## Operation
- **FSM states:**
  - `IDLE`: evaluate whether to pop.
  - `POP`: `rd_en_o`=1.
  - `CAPT`: capture `fifo_dout_i` into the output buffer; `rd_en_o`=0.
- **Transitions:**
  - `IDLE`→`POP` when `!empty_i && occ<2`. Otherwise stay in `IDLE`.
  - `POP`→`CAPT` unconditionally.
  - `CAPT`→`IDLE` unconditionally. `empty_i` is stale in `CAPT` and is never sampled there.
- **Pop rule:** a pop is issued only from a state whose `empty_i` sample is trustworthy. The block therefore never pops an empty FIFO.
- **Output buffer:** 2-entry skid buffer, occupancy `occ` in 0..2, in-order. `valid_o`=(`occ`!=0). `data_o`=head entry.
- **Simultaneous capture and drain:** both occur in the same cycle. `occ` is unchanged and order is preserved.
- **Space check:** the check in `IDLE` guarantees the in-flight word always has a slot. Capture never overflows.
- **Consumer stall:** `data_o` and `valid_o` hold stable while `valid_o && !ready_i`.

## Timing
- **Reset values:** `rd_en_o`=0, `valid_o`=0, `data_o`=0, `occ`=0, state=`IDLE`, counters=0.
- **Reset mid-operation:** any in-flight pop and all buffered words are discarded. The consumed FIFO word is lost, and this is accepted behaviour.
- **Latency:** if `empty_i` is low in `IDLE` at cycle t, then `rd_en_o`=1 in t+1, capture happens at the end of t+2, and `valid_o`=1 with the word in t+3.
- **Throughput:** at most 1 word per 3 cycles.
- **Ordering:** output order equals FIFO pop order.
- **Downstream full:** with `ready_i` held low, exactly 2 pops occur, then `rd_en_o` stays 0 until `occ` drops below 2.
- **Counters:** 32-bit, wrap modulo 2^32.

## Configuration
- `FIFO_DRAIN_STATS_EN`, when defined: `pop_cnt_o` increments on every cycle with `rd_en_o`=1, and `stall_cnt_o` increments on every cycle with `valid_o && !ready_i`.
- When undefined: the counters and both ports are absent. Functional behaviour is otherwise identical.

## Structure
- **Package `fifo_drain_pkg`:**
  - state encodings: `IDLE`=2'd0, `POP`=2'd1, `CAPT`=2'd2;
  - skid depth constant `SKID_DEPTH`=2;
  - counter width `STAT_W`=32.
- **Sub-module `drain_skid`:**
  - 2-entry in-order buffer with push and pop ports;
  - exposes `occ` and the head word;
  - instantiated once.
- **Top level** holds the FSM and the optional counters.

## Test plan
1. **Reset defaults:** assert `reset_i` for 2 cycles with `empty_i`=0 → `rd_en_o`=0, `valid_o`=0, `data_o`=0 throughout. The first `rd_en_o` appears 2 cycles after reset deasserts.
2. **Single word:** FIFO holds 0xA5, `ready_i`=1 → one `rd_en_o` pulse, then `valid_o` high for exactly one cycle with `data_o`=0xA5. No further pops once `empty_i` rises.
3. **Stream with stall:** FIFO holds 0x01..0x04, `ready_i`=0 → exactly 2 pops and `valid_o` stays high with `data_o`=0x01. Raising `ready_i` then yields 0x01, 0x02, 0x03, 0x04 in order.
4. **Lagging empty:** FIFO holds 1 word and `empty_i` stays low for 1 cycle after the pop → no second `rd_en_o` is issued.
5. **Reset mid-operation:** assert reset in the `CAPT` cycle with `occ`=1 → next cycle `valid_o`=0, `occ`=0, state=`IDLE`.
6. **Stats (with `FIFO_DRAIN_STATS_EN`):** 3 words with `ready_i` low for 5 cycles while valid → `pop_cnt_o`=3, `stall_cnt_o`=5.
